// File: rtl/register_file_2r1w_pkg.sv
// Shared types and constants for the 2-read / 1-write register file slice.
// Package rf_pkg: default geometry, data/address typedefs, accumulator target.
package rf_pkg;

  localparam int unsigned RF_W = 8;
  localparam int unsigned RF_D = 4;

  typedef logic [RF_D-1:0] rf_addr_t;
  typedef logic [RF_W-1:0] rf_data_t;

  localparam int unsigned ACC_REG = 0;

  // Which writer ends up owning register 0 in a given cycle.
  typedef enum logic [1:0] {
    ZSRC_NONE = 2'd0,
    ZSRC_GEN  = 2'd1,
    ZSRC_ACC  = 2'd2
  } zero_src_e;

endpackage

// File: rtl/register_file_2r1w_write_arbiter.sv
// Combinational resolution of the general and accumulator writers into
// effective register-0 and non-zero-register writes plus a raw collision flag.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned W = RF_W,
  parameter int unsigned D = RF_D
) (
  input  logic         wr_en,
  input  logic [D-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic         acc_wr_en,
  input  logic [W-1:0] acc_data,
  output logic         gen_en,
  output logic [D-1:0] gen_addr,
  output logic [W-1:0] gen_data,
  output logic         zero_en,
  output logic [W-1:0] zero_data,
  output logic         conflict
);

  localparam logic [D-1:0] ACC_ADDR = D'(ACC_REG);

  zero_src_e zero_src;
  logic      gen_hits_zero;

  always_comb begin
    gen_hits_zero = wr_en && (wr_addr == ACC_ADDR);

    // General port owns register 0 whenever it targets it.
    if (gen_hits_zero) begin
      zero_src = ZSRC_GEN;
    end else if (acc_wr_en) begin
      zero_src = ZSRC_ACC;
    end else begin
      zero_src = ZSRC_NONE;
    end

    zero_en   = (zero_src != ZSRC_NONE);
    zero_data = (zero_src == ZSRC_GEN) ? wr_data : acc_data;

    gen_en   = wr_en && !gen_hits_zero;
    gen_addr = wr_addr;
    gen_data = wr_data;

    conflict = gen_hits_zero && acc_wr_en;
  end

endmodule

// File: rtl/register_file_2r1w.sv
// 2**D x W register file: two combinational read ports, general + accumulator
// writers, written-since-reset scoreboard. Optional macro: RF_WRITE_BYPASS_EN.
module register_file_2r1w
  import rf_pkg::*;
#(
  parameter int unsigned W = RF_W,
  parameter int unsigned D = RF_D
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [D-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic         acc_wr_en,
  input  logic [W-1:0] acc_data,
  input  logic [D-1:0] rd_addr_a,
  output logic [W-1:0] rd_data_a,
  input  logic [D-1:0] rd_addr_b,
  output logic [W-1:0] rd_data_b,
  output logic         rd_valid_a,
  output logic         rd_valid_b,
  output logic [W-1:0] reg_zero,
  output logic         wr_conflict
);

  localparam int unsigned N = 2 ** D;
  localparam logic [D-1:0] ACC_ADDR = D'(ACC_REG);

  logic [W-1:0] regs_q  [N];
  logic [W-1:0] regs_d  [N];
  logic [N-1:0] valid_q;
  logic [N-1:0] valid_d;
  logic         wr_conflict_q;
  logic         wr_conflict_d;

  logic         gen_en;
  logic [D-1:0] gen_addr;
  logic [W-1:0] gen_data;
  logic         zero_en;
  logic [W-1:0] zero_data;
  logic         conflict;

  rf_write_arbiter #(
    .W (W),
    .D (D)
  ) u_arb (
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .acc_wr_en (acc_wr_en),
    .acc_data  (acc_data),
    .gen_en    (gen_en),
    .gen_addr  (gen_addr),
    .gen_data  (gen_data),
    .zero_en   (zero_en),
    .zero_data (zero_data),
    .conflict  (conflict)
  );

  always_comb begin
    regs_d        = regs_q;
    valid_d       = valid_q;
    wr_conflict_d = 1'b0;
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        regs_d[i] = '0;
      end
      valid_d = '0;
    end else begin
      // gen_en never targets register 0, so the two writes cannot overlap.
      if (gen_en) begin
        regs_d[gen_addr]  = gen_data;
        valid_d[gen_addr] = 1'b1;
      end
      if (zero_en) begin
        regs_d[ACC_REG]  = zero_data;
        valid_d[ACC_REG] = 1'b1;
      end
      wr_conflict_d = conflict;
    end
  end

  always_ff @(posedge clk) begin
    regs_q        <= regs_d;
    valid_q       <= valid_d;
    wr_conflict_q <= wr_conflict_d;
  end

  always_comb begin
    rd_data_a  = regs_q[rd_addr_a];
    rd_valid_a = valid_q[rd_addr_a];
    rd_data_b  = regs_q[rd_addr_b];
    rd_valid_b = valid_q[rd_addr_b];
    reg_zero   = regs_q[ACC_REG];
`ifdef RF_WRITE_BYPASS_EN
    if (!reset) begin
      if (zero_en && (rd_addr_a == ACC_ADDR)) begin
        rd_data_a  = zero_data;
        rd_valid_a = 1'b1;
      end else if (gen_en && (rd_addr_a == gen_addr)) begin
        rd_data_a  = gen_data;
        rd_valid_a = 1'b1;
      end
      if (zero_en && (rd_addr_b == ACC_ADDR)) begin
        rd_data_b  = zero_data;
        rd_valid_b = 1'b1;
      end else if (gen_en && (rd_addr_b == gen_addr)) begin
        rd_data_b  = gen_data;
        rd_valid_b = 1'b1;
      end
      if (zero_en) begin
        reg_zero = zero_data;
      end
    end
`endif
  end

  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Self-checking bench for register_file_2r1w: array model + directed vectors.
module tb_register_file_2r1w;

  localparam int W = 8;
  localparam int D = 4;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [D-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic         acc_wr_en;
  logic [W-1:0] acc_data;
  logic [D-1:0] rd_addr_a;
  logic [W-1:0] rd_data_a;
  logic [D-1:0] rd_addr_b;
  logic [W-1:0] rd_data_b;
  logic         rd_valid_a;
  logic         rd_valid_b;
  logic [W-1:0] reg_zero;
  logic         wr_conflict;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  logic [W-1:0] m_regs  [N];
  bit           m_valid [N];
  bit           m_conflict;

  register_file_2r1w #(.W(W), .D(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .acc_wr_en   (acc_wr_en),
    .acc_data    (acc_data),
    .rd_addr_a   (rd_addr_a),
    .rd_data_a   (rd_data_a),
    .rd_addr_b   (rd_addr_b),
    .rd_data_b   (rd_data_b),
    .rd_valid_a  (rd_valid_a),
    .rd_valid_b  (rd_valid_b),
    .reg_zero    (reg_zero),
    .wr_conflict (wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: apply accumulator then general write, so the general port wins on register 0.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_regs[i]  = '0;
        m_valid[i] = 1'b0;
      end
      m_conflict = 1'b0;
    end else begin
      m_conflict = wr_en && (wr_addr == 0) && acc_wr_en;
      if (acc_wr_en) begin
        m_regs[0]  = acc_data;
        m_valid[0] = 1'b1;
      end
      if (wr_en) begin
        m_regs[wr_addr]  = wr_data;
        m_valid[wr_addr] = 1'b1;
      end
    end
  end

  function automatic logic [W:0] model_read(input logic [D-1:0] a);
    logic [W-1:0] d;
    bit v;
    d = m_regs[a];
    v = m_valid[a];
`ifdef RF_WRITE_BYPASS_EN
    if (!reset) begin
      if (acc_wr_en && a == 0) begin
        d = acc_data;
        v = 1'b1;
      end
      if (wr_en && wr_addr == a) begin
        d = wr_data;
        v = 1'b1;
      end
    end
`endif
    return {v, d};
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      logic [W:0] ea;
      logic [W:0] eb;
      logic [W:0] ez;
      ea = model_read(rd_addr_a);
      eb = model_read(rd_addr_b);
      ez = model_read('0);
      chk("model rd_data_a", 32'(rd_data_a), 32'(ea[W-1:0]));
      chk("model rd_valid_a", 32'(rd_valid_a), 32'(ea[W]));
      chk("model rd_data_b", 32'(rd_data_b), 32'(eb[W-1:0]));
      chk("model rd_valid_b", 32'(rd_valid_b), 32'(eb[W]));
      chk("model reg_zero", 32'(reg_zero), 32'(ez[W-1:0]));
      chk("model wr_conflict", 32'(wr_conflict), 32'(m_conflict));
    end
  end

  task automatic edge_step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    wr_en     = 1'b0;
    acc_wr_en = 1'b0;
    reset     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hAA;
    acc_wr_en = 1'b0; acc_data = 8'h00;
    rd_addr_a = '0; rd_addr_b = '0;
    edge_step();
    edge_step();
    idle();
    check_en = 1'b1;

    // Reset state, including the write that was issued during reset.
    for (int i = 0; i < N; i++) begin
      rd_addr_a = 4'(i);
      rd_addr_b = 4'(N - 1 - i);
      #1;
      chk("reset rd_data_a", 32'(rd_data_a), 32'h0);
      chk("reset rd_valid_b", 32'(rd_valid_b), 32'h0);
    end
    chk("reset reg_zero", 32'(reg_zero), 32'h0);
    chk("reset wr_conflict", 32'(wr_conflict), 32'h0);

    // Plain write then dual read of the same address.
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h5C;
    edge_step();
    idle();
    rd_addr_a = 4'd7; rd_addr_b = 4'd7;
    #1;
    chk("w7 rd_data_a", 32'(rd_data_a), 32'h5C);
    chk("w7 rd_data_b", 32'(rd_data_b), 32'h5C);
    chk("w7 rd_valid_a", 32'(rd_valid_a), 32'h1);
    rd_addr_a = 4'd6;
    #1;
    chk("a6 rd_data_a", 32'(rd_data_a), 32'h0);
    chk("a6 rd_valid_a", 32'(rd_valid_a), 32'h0);

    // Collision on register 0.
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h11;
    acc_wr_en = 1'b1; acc_data = 8'h22;
    edge_step();
    idle();
    rd_addr_a = 4'd0;
    #1;
    chk("coll reg_zero", 32'(reg_zero), 32'h11);
    chk("coll wr_conflict", 32'(wr_conflict), 32'h1);
    chk("coll rd_valid_a", 32'(rd_valid_a), 32'h1);
    edge_step();
    chk("coll wr_conflict drop", 32'(wr_conflict), 32'h0);
    chk("coll reg_zero hold", 32'(reg_zero), 32'h11);

    // Non-colliding dual write.
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 8'h33;
    acc_wr_en = 1'b1; acc_data = 8'h44;
    edge_step();
    idle();
    rd_addr_a = 4'd9;
    #1;
    chk("dual rd_data_a", 32'(rd_data_a), 32'h33);
    chk("dual reg_zero", 32'(reg_zero), 32'h44);
    chk("dual wr_conflict", 32'(wr_conflict), 32'h0);

    // Read-during-write on address 5.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h12;
    edge_step();
    wr_data = 8'h77;
    rd_addr_a = 4'd5;
    #1;
`ifdef RF_WRITE_BYPASS_EN
    chk("rdw same-cycle", 32'(rd_data_a), 32'h77);
`else
    chk("rdw same-cycle", 32'(rd_data_a), 32'h12);
`endif
    edge_step();
    idle();
    #1;
    chk("rdw next-cycle", 32'(rd_data_a), 32'h77);

    // Fill every register, reset on the last cycle, then everything reads back cleared.
    for (int i = 0; i < N; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 8'(i) ^ 8'hF0;
      if (i == N - 1) reset = 1'b1;
      edge_step();
      if (i == N - 2) begin
        rd_addr_a = 4'd14;
        #1;
        chk("fill a14", 32'(rd_data_a), 32'hFE);
      end
    end
    idle();
    for (int i = 0; i < N; i++) begin
      rd_addr_a = 4'(i);
      rd_addr_b = 4'(i);
      #1;
      chk("post-reset rd_data_a", 32'(rd_data_a), 32'h0);
      chk("post-reset rd_valid_b", 32'(rd_valid_b), 32'h0);
    end
    edge_step();
    edge_step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
